sonar_scheduler: RTL
====================

// Module: sonar_scheduler
// PURPOSE
//  Time-multiplexes the front and back sonar_range instances so only one transducer fires at a time.
//  Without this, crosstalk occurs when both sensors are triggered from one start signal.
//  Issues one-cycle start pulses, waits for valid or timeout, then latches the distance and derives stop.
//  Inserts a settle gap between measurements. Sits between the sonar_range pair and obstacle/display logic.
//  Runs in the SONAR_CLK domain.
// PARAMETERS
//  DIST_W          12         width of distance values (mm)
//  TIMEOUT_CYCLES  1_756_160  max wait for valid after start (40 ms @ 43.904 MHz)
//  GAP_CYCLES      2_634_240  idle gap after each measurement before next start (60 ms)
//  THRESHOLD       1000       stop asserted when latched distance < THRESHOLD (mm)
// PORTS
//  clk             in   1       SONAR_CLK
//  rst             in   1       synchronous, active-high reset
//  enable          in   1       1 = run alternating measurement schedule
//  ready_front     in   1       front sonar_range idle/ready
//  valid_front     in   1       front measurement done, distance_front valid this cycle
//  distance_front  in   DIST_W  front raw distance
//  ready_back      in   1       back sonar_range idle/ready
//  valid_back      in   1       back measurement done
//  distance_back   in   DIST_W  back raw distance
//  start_front     out  1       one-cycle start pulse to front sensor
//  start_back      out  1       one-cycle start pulse to back sensor
//  dist_front      out  DIST_W  last good front distance
//  dist_back       out  DIST_W  last good back distance
//  fresh_front     out  1       one-cycle pulse when dist_front updated
//  fresh_back      out  1       one-cycle pulse when dist_back updated
//  timeout_front   out  1       last front measurement timed out
//  timeout_back    out  1       last back measurement timed out
//  stop_front      out  1       front obstacle / fail-safe stop
//  stop_back       out  1       back obstacle / fail-safe stop
//  sel_back        out  1       current sensor: 0 = front, 1 = back
// BEHAVIOUR
//  Reset: state=IDLE, sel_back=0, counter=0, every output 0 (dist_* = 0).
//  FSM: IDLE -> START -> WAIT -> GAP -> START ...
//  IDLE: if enable -> START (sel_back unchanged).
//  START: if !enable -> IDLE. Else if ready_<sel>, assert start_<sel> for exactly 1 cycle
//    (registered, cycle after condition seen), clear counter -> WAIT. Otherwise hold in START.
//  WAIT: counter increments each cycle.
//    - valid_<sel>=1: dist_<sel> <= distance_<sel>; fresh_<sel> pulses 1 cycle (same cycle dist updates);
//      timeout_<sel> <= 0; stop_<sel> <= (distance_<sel> < THRESHOLD) -> GAP, counter cleared.
//    - counter == TIMEOUT_CYCLES-1 and no valid: timeout_<sel> <= 1; stop_<sel> <= 1 (fail-safe);
//      dist_<sel> held; no fresh pulse -> GAP.
//    - valid and timeout on same cycle: valid wins.
//  GAP: count GAP_CYCLES cycles, then toggle sel_back. -> START if enable, else IDLE.
//  enable is ignored in WAIT/GAP; an in-flight measurement always completes.
//  Valid/ready from the non-selected sensor is ignored. start_* never both high; never high outside START exit.
//  Distance compare is unsigned DIST_W bits. Distance 0 is a legal value (gives stop=1 if THRESHOLD>0).
//  Counters sized $clog2(max(TIMEOUT_CYCLES,GAP_CYCLES)+1); no wrap-around.
//  rst mid-operation: all state and outputs return to reset values on the next clk edge; a pending start is dropped.
// TESTING (bench uses TIMEOUT_CYCLES=20, GAP_CYCLES=10, THRESHOLD=1000)
//  1. rst, enable=1, both ready=1 -> start_front 1-cycle pulse; valid_front with 1500 -> dist_front=1500,
//     fresh_front pulse, stop_front=0; 10 cycles later start_back pulses.
//  2. back valid with 800 -> dist_back=800, stop_back=1; next start is start_front (alternation).
//  3. start_back issued, no valid_back for 20 cycles -> timeout_back=1, stop_back=1, dist_back unchanged,
//     no fresh_back; next good valid clears timeout_back.
//  4. valid_front arrives on the exact timeout cycle -> treated as valid (fresh pulse, timeout_front=0);
//     valid_back during front WAIT -> ignored.
//  5. ready_front=0 in START -> no start pulse until ready rises; enable dropped in WAIT -> measurement
//     completes, GAP, then IDLE with no further starts.
//  6. rst asserted in WAIT and in GAP -> next cycle all outputs 0, sel_back=0, no spurious start.

Source files
------------

// File: rtl/sonar_scheduler.sv
// Alternates measurements between the front and back sonar_range instances so only one transducer fires
// at a time, latching distances, timeouts and stop flags and inserting a settle gap between measurements.
module sonar_scheduler #(
    parameter int unsigned DIST_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1_756_160,
    parameter int unsigned GAP_CYCLES     = 2_634_240,
    parameter int unsigned THRESHOLD      = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ready_front,
    input  logic              valid_front,
    input  logic [DIST_W-1:0] distance_front,
    input  logic              ready_back,
    input  logic              valid_back,
    input  logic [DIST_W-1:0] distance_back,
    output logic              start_front,
    output logic              start_back,
    output logic [DIST_W-1:0] dist_front,
    output logic [DIST_W-1:0] dist_back,
    output logic              fresh_front,
    output logic              fresh_back,
    output logic              timeout_front,
    output logic              timeout_back,
    output logic              stop_front,
    output logic              stop_back,
    output logic              sel_back,
    output logic [1:0]        dbg_state_o
);

    // Handshake: start_<sel> is a one-cycle pulse issued only when ready_<sel> was seen in START;
    // valid_<sel> is sampled only while waiting on the selected sensor, the other sensor is ignored.

    localparam int unsigned MAX_CYC = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    // One extra bit so a threshold of exactly 2**DIST_W still compares correctly.
    localparam logic [DIST_W:0]   THR      = (DIST_W + 1)'(THRESHOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sel_back_q, sel_back_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_front_q, start_front_d;
    logic               start_back_q, start_back_d;
    logic [DIST_W-1:0]  dist_front_q, dist_front_d;
    logic [DIST_W-1:0]  dist_back_q, dist_back_d;
    logic               fresh_front_q, fresh_front_d;
    logic               fresh_back_q, fresh_back_d;
    logic               timeout_front_q, timeout_front_d;
    logic               timeout_back_q, timeout_back_d;
    logic               stop_front_q, stop_front_d;
    logic               stop_back_q, stop_back_d;

    logic               sel_ready;
    logic               sel_valid;
    logic [DIST_W-1:0]  sel_dist;
    logic               sel_below;

    assign sel_ready = sel_back_q ? ready_back    : ready_front;
    assign sel_valid = sel_back_q ? valid_back    : valid_front;
    assign sel_dist  = sel_back_q ? distance_back : distance_front;
    assign sel_below = ({1'b0, sel_dist} < THR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            sel_back_q      <= 1'b0;
            cnt_q           <= '0;
            start_front_q   <= 1'b0;
            start_back_q    <= 1'b0;
            dist_front_q    <= '0;
            dist_back_q     <= '0;
            fresh_front_q   <= 1'b0;
            fresh_back_q    <= 1'b0;
            timeout_front_q <= 1'b0;
            timeout_back_q  <= 1'b0;
            stop_front_q    <= 1'b0;
            stop_back_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sel_back_q      <= sel_back_d;
            cnt_q           <= cnt_d;
            start_front_q   <= start_front_d;
            start_back_q    <= start_back_d;
            dist_front_q    <= dist_front_d;
            dist_back_q     <= dist_back_d;
            fresh_front_q   <= fresh_front_d;
            fresh_back_q    <= fresh_back_d;
            timeout_front_q <= timeout_front_d;
            timeout_back_q  <= timeout_back_d;
            stop_front_q    <= stop_front_d;
            stop_back_q     <= stop_back_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        sel_back_d      = sel_back_q;
        cnt_d           = cnt_q;
        start_front_d   = 1'b0;
        start_back_d    = 1'b0;
        dist_front_d    = dist_front_q;
        dist_back_d     = dist_back_q;
        fresh_front_d   = 1'b0;
        fresh_back_d    = 1'b0;
        timeout_front_d = timeout_front_q;
        timeout_back_d  = timeout_back_q;
        stop_front_d    = stop_front_q;
        stop_back_d     = stop_back_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (sel_ready) begin
                    start_back_d  = sel_back_q;
                    start_front_d = !sel_back_q;
                    cnt_d         = '0;
                    state_d       = S_WAIT;
                end
            end

            S_WAIT: begin
                // A valid on the final timeout cycle still counts as a good measurement.
                if (sel_valid) begin
                    if (sel_back_q) begin
                        dist_back_d    = sel_dist;
                        fresh_back_d   = 1'b1;
                        timeout_back_d = 1'b0;
                        stop_back_d    = sel_below;
                    end else begin
                        dist_front_d    = sel_dist;
                        fresh_front_d   = 1'b1;
                        timeout_front_d = 1'b0;
                        stop_front_d    = sel_below;
                    end
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == TO_LAST) begin
                    if (sel_back_q) begin
                        timeout_back_d = 1'b1;
                        stop_back_d    = 1'b1;
                    end else begin
                        timeout_front_d = 1'b1;
                        stop_front_d    = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d      = '0;
                    sel_back_d = !sel_back_q;
                    state_d    = enable ? S_START : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign start_front   = start_front_q;
    assign start_back    = start_back_q;
    assign dist_front    = dist_front_q;
    assign dist_back     = dist_back_q;
    assign fresh_front   = fresh_front_q;
    assign fresh_back    = fresh_back_q;
    assign timeout_front = timeout_front_q;
    assign timeout_back  = timeout_back_q;
    assign stop_front    = stop_front_q;
    assign stop_back     = stop_back_q;
    assign sel_back      = sel_back_q;
    assign dbg_state_o   = state_q;

endmodule
